// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_pkg
// Brief   : Shared types, status codes and priority-match helper for the
//           pipeline hazard scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam int MAX_RW    = 8;
    localparam int MAX_DEPTH = 16;

    localparam int ST_CLEAN    = 0;
    localparam int ST_PEND     = 1;
    localparam int ST_FWD_BASE = 2;

    typedef logic [MAX_RW-1:0] sb_dst_t;
    typedef logic [7:0]        sb_status_t;

    typedef struct packed {
        logic    v;
        sb_dst_t dst;
        logic    ld;
    } sb_entry_t;

    typedef sb_entry_t [MAX_DEPTH-1:0] sb_entries_t;

    // Walk from oldest to youngest so the smallest matching stage index wins.
    function automatic sb_status_t status_of(input sb_entries_t e,
                                             input int          depth,
                                             input int          load_avail,
                                             input sb_dst_t     r);
        sb_status_t s;
        s = sb_status_t'(ST_CLEAN);
        for (int k = MAX_DEPTH-1; k >= 0; k--) begin
            if (k < depth && e[k].v && e[k].dst == r) begin
                if (e[k].ld && k < load_avail)
                    s = sb_status_t'(ST_PEND);
                else
                    s = sb_status_t'(k + ST_FWD_BASE);
            end
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_match.sv
`default_nettype none
// ============================================================================
// Module  : sb_match
// Brief   : Priority match of one register address against all in-flight
//           entries, producing its status code.
// Revision: 1.0 - initial release
// ============================================================================
module sb_match
    import hazard_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_AVAIL = 1,
    parameter int RW         = 3,
    parameter int SW         = 3
) (
    input  logic [RW-1:0]               reg_adr,
    input  sb_entry_t [DEPTH-1:0]       entries,
    output logic [SW-1:0]               status
);

    sb_entries_t w_all;

    always_comb begin
        w_all              = '0;
        w_all[DEPTH-1:0]   = entries;
    end

    assign status = SW'(status_of(w_all, DEPTH, LOAD_AVAIL, sb_dst_t'(reg_adr)));

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : hazard_scoreboard
// Brief   : Tracks in-flight destination registers after ID and returns
//           per-operand forwarding selects, a stall request and stall count.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG       = 8,
    parameter int DEPTH      = 3,
    parameter int NSRC       = 2,
    parameter int LOAD_AVAIL = 1,
    parameter int CNT_W      = 16,
    localparam int RW        = $clog2(NREG),
    localparam int SW        = $clog2(DEPTH+2)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic                       issue_we,
    input  logic                       issue_load,
    input  logic [RW-1:0]              issue_dst,
    input  logic [NSRC-1:0]            src_en,
    input  logic [NSRC-1:0][RW-1:0]    src_adr,
    input  logic                       flush,
    output logic                       stall,
    output logic [NSRC-1:0][SW-1:0]    fwd_sel,
    output logic [NREG-1:0][SW-1:0]    reg_status,
    output logic                       issued,
    output logic [CNT_W-1:0]           stall_cnt
);

    sb_entry_t [DEPTH-1:0] r_entries;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic                  w_pend;

    generate
        for (genvar r = 0; r < NREG; r++) begin : g_match
            localparam logic [RW-1:0] C_ADR = RW'(r);
            sb_match #(
                .DEPTH      (DEPTH),
                .LOAD_AVAIL (LOAD_AVAIL),
                .RW         (RW),
                .SW         (SW)
            ) u_match (
                .reg_adr (C_ADR),
                .entries (r_entries),
                .status  (reg_status[r])
            );
        end
    endgenerate

    // Stall looks at reg_status directly, never at this cycle's fwd_sel.
    always_comb begin
        w_pend  = 1'b0;
        fwd_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_en[i]) begin
                fwd_sel[i] = reg_status[src_adr[i]];
                if (reg_status[src_adr[i]] == SW'(ST_PEND))
                    w_pend = 1'b1;
            end
        end
    end

    assign stall     = !flush && issue_valid && w_pend;
    assign issued    = issue_valid && issue_we && !stall && !flush;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_entries <= '0;
        end else begin
            for (int k = DEPTH-1; k > 0; k--)
                r_entries[k] <= r_entries[k-1];
            r_entries[0] <= '{v: issued, dst: sb_dst_t'(issue_dst), ld: issue_load};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (stall && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised scoreboard for the in-order 16-bit pipeline. It tracks in-flight destination registers across the post-ID stages and replaces the fixed per-register invalid codes with state derived cycle by cycle.
- Per ID-stage source operand: a forwarding select and a stall request.
- Per register: a status vector.
- Flush on taken jump.
- A saturating stall performance counter.
Sits beside the ID-stage controller: the controller supplies the decoded issue, and the scoreboard returns select/stall.

Parameters:
NREG, 8, architectural register count (power of two)
DEPTH, 3, tracked stages after ID (stage 0 = EX … DEPTH-1 = WB)
NSRC, 2, source operands checked per issued instruction
LOAD_AVAIL, 1, first stage index whose output carries load data
CNT_W, 16, stall counter width
Derived: RW = $clog2(NREG); SW = $clog2(DEPTH+2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
issue_valid  in  1  ID holds a real (non-flushed) instruction
issue_we  in  1  instruction writes a register
issue_load  in  1  instruction is a load (data from main memory)
issue_dst  in  RW  destination register
src_en  in  NSRC  operand i reads a register
src_adr  in  NSRC×RW  operand register addresses
flush  in  1  taken jump resolved this cycle
stall  out  1  hold PC/IFID, inject bubble into IDEX
fwd_sel  out  NSRC×SW  per operand: 0 regfile, k+2 forward from stage k
reg_status  out  NREG×SW  per register: 0 clean, 1 pending-unforwardable, k+2 youngest writer in stage k
issued  out  1  entry pushed this cycle (issue_valid & issue_we & !stall & !flush)
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset value of every output: state is a DEPTH-entry shift array {v, dst, ld}. rst clears every v, and stall_cnt goes to 0. All outputs are then 0 (stall=0, fwd_sel=0, reg_status=0, issued=0).
- Advance (every cycle, unconditional; downstream stages never stall):
  - entry[k+1] <= entry[k].
  - entry[DEPTH-1] retires.
  - entry[0] <= {issued, issue_dst, issue_load}; otherwise a bubble (v=0).
- Status of register r (combinational from registered state only):
  - Find the smallest k with v & dst==r; the youngest writer wins.
  - No match -> 0.
  - Match with ld=1 and k<LOAD_AVAIL -> 1.
  - Otherwise -> k+2.
- Stall:
  - stall = !flush & issue_valid & OR_i(src_en[i] & reg_status[src_adr[i]]==1).
  - Combinational; it must not depend on fwd_sel from the same cycle.
- Forwarding:
  - fwd_sel[i] = src_en[i] ? reg_status[src_adr[i]] : 0.
  - A value of 1 is only visible when stall=1, and the consumer ignores it.
- Flush:
  - Next cycle all v=0, and there is no push that cycle.
  - flush dominates stall.
  - flush together with issue_valid: the instruction is discarded.
- A stalled instruction re-presents in later cycles. The producing load advances, so stall clears after exactly LOAD_AVAIL-k cycles.
- A WB-stage match (k=DEPTH-1) forwards. There is no regfile write-through assumption.
- Same dst in several stages: the youngest stage is reported, and older entries are shadowed.
- issue_we=0 or issue_valid=0: a bubble is pushed.
- stall_cnt increments on each cycle with stall=1 and saturates at all-ones. It is cleared only by rst.
- rst mid-operation: all in-flight entries are dropped on that edge. There is no partial state.

Decomposition:
- Package hazard_pkg holds:
  - the entry struct {v, dst, ld};
  - constants ST_CLEAN=0, ST_PEND=1, ST_FWD_BASE=2;
  - helper function status_of(entries, r).
- One sub-module, sb_match, performs the priority match of one register address against all entries and returns SW-bit status.
  - It is instantiated NREG times for reg_status.
  - Operand lookup indexes reg_status by src_adr.

Test Plan:
- Reset, then idle 3 cycles -> stall=0, all reg_status=0, stall_cnt=0.
- ALU write to r3 at cycle 0, reader of r3 at cycle 1 -> fwd_sel=2. At cycle 2 -> 3. At cycle 3 -> 4. At cycle 4 -> 0.
- Load to r5 followed immediately by a reader of r5 (LOAD_AVAIL=1):
  - cycle 1: stall=1, issued=0, stall_cnt=1.
  - cycle 2: stall=0, fwd_sel=3.
- Two ALU writes to r2 in consecutive cycles, then a reader of r2 -> fwd_sel=2 (youngest writer); reg_status[2]=2.
- Load r1 pending with a stalled reader of r1, flush asserted -> stall=0 that cycle. The next cycle all reg_status=0 and issued=0.
- Force 2^CNT_W+3 stall cycles (CNT_W=4) -> stall_cnt saturates at 15. rst then returns it to 0.
